// File: rtl/usb_devstate_ctrl.sv
// USB device-state controller: tracks the chapter-9 device state, the
// committed address and configuration, per-endpoint enable/halt flags and
// data-toggle resets, and sequences remote wakeup out of suspend.

// Per-endpoint halt flag and data-toggle reset pulse (one lane per non-control EP).
module usb_devstate_ep (
    input  logic clk_4xrate,
    input  logic rst1_sync,
    input  logic usb_rst,
    input  logic cfg_accept,
    input  logic ep_enable,
    input  logic ep_halt_set,
    input  logic ep_halt_clr,
    output logic ep_halt,
    output logic togglebit_rst
);

    // Halt flag: clear wins over set; set is only honoured on a usable endpoint.
    // A clear on an enabled endpoint resets its toggle even if it was not halted.
    always_ff @(posedge clk_4xrate) begin
        if (rst1_sync) begin
            ep_halt       <= 1'b0;
            togglebit_rst <= 1'b0;
        end else begin
            togglebit_rst <= cfg_accept | (ep_halt_clr & ep_enable);
            if (usb_rst || cfg_accept || ep_halt_clr)
                ep_halt <= 1'b0;
            else if (ep_halt_set && ep_enable)
                ep_halt <= 1'b1;
        end
    end

endmodule

module usb_devstate_ctrl #(
    parameter int NUM_EP              = 16,
    parameter int WAKEUP_IDLE_CYCLES  = 240000,
    parameter int WAKEUP_DRIVE_CYCLES = 48000
) (
    input  logic              clk_4xrate,
    input  logic              rst1_sync,
    input  logic              usb_rst,
    input  logic              usb_spnd,
    input  logic              device_addr_wr,
    input  logic [6:0]        device_addr,
    input  logic              addr_commit,
    input  logic              device_config_wr,
    input  logic [7:0]        device_config,
    input  logic [NUM_EP-1:1] ep_cfg_enable,
    input  logic [NUM_EP-1:1] ep_halt_set,
    input  logic [NUM_EP-1:1] ep_halt_clr,
    input  logic              remote_wakeup_en,
    input  logic              device_wakeup,
    output logic [2:0]        device_state,
    output logic [6:0]        dev_addr,
    output logic [7:0]        dev_config,
    output logic [NUM_EP-1:1] ep_enable,
    output logic [NUM_EP-1:1] ep_halt,
    output logic [NUM_EP-1:0] togglebit_rst,
    output logic              remote_wakeup,
    output logic              wakeup_busy
);

    localparam int IW = $clog2(WAKEUP_IDLE_CYCLES + 1);
    localparam int DW = $clog2(WAKEUP_DRIVE_CYCLES + 1);

    // Bit 2 of the encoding marks the suspended twin of each base state.
    typedef enum logic [2:0] {
        POWERED    = 3'd0,
        DEFAULT    = 3'd1,
        ADDRESSED  = 3'd2,
        CONFIGURED = 3'd3,
        SPND_PWR   = 3'd4,
        SPND_DFT   = 3'd5,
        SPND_ADDR  = 3'd6,
        SPND_CONF  = 3'd7
    } dev_state_t;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_WAIT  = 2'd1,
        W_DRIVE = 2'd2,
        W_HOLD  = 2'd3
    } wake_state_t;

    dev_state_t        state;
    wake_state_t       wstate;
    logic [6:0]        addr_pend;
    logic [IW-1:0]     idle_cnt;
    logic [IW-1:0]     idle_nxt;
    logic [DW-1:0]     drv_cnt;
    logic              tog0_q;
    logic [NUM_EP-1:1] lane_tog;
    logic              suspended;
    logic              cfg_accept;

    assign device_state = state;
    assign suspended    = state[2];
    assign togglebit_rst = {lane_tog, tog0_q};

    // A bus reset in the same cycle overrides any configuration write.
    assign cfg_accept = device_config_wr && !usb_rst &&
                        (state == ADDRESSED || state == CONFIGURED);

    // Device state machine; transitions look at the committed address/config.
    always_ff @(posedge clk_4xrate) begin
        if (rst1_sync) begin
            state <= POWERED;
        end else begin
            case (state)
                POWERED:    if (usb_rst)                          state <= DEFAULT;
                            else if (usb_spnd)                    state <= SPND_PWR;
                DEFAULT:    if (usb_spnd)                         state <= SPND_DFT;
                            else if (dev_addr != 7'd0)            state <= ADDRESSED;
                ADDRESSED:  if (usb_rst || dev_addr == 7'd0)      state <= DEFAULT;
                            else if (usb_spnd)                    state <= SPND_ADDR;
                            else if (dev_config != 8'd0)          state <= CONFIGURED;
                CONFIGURED: if (usb_rst)                          state <= DEFAULT;
                            else if (usb_spnd)                    state <= SPND_CONF;
                            else if (dev_config == 8'd0)          state <= ADDRESSED;
                SPND_PWR:   if (usb_rst)                          state <= DEFAULT;
                            else if (!usb_spnd)                   state <= POWERED;
                SPND_DFT:   if (usb_rst)                          state <= DEFAULT;
                            else if (!usb_spnd)                   state <= DEFAULT;
                SPND_ADDR:  if (usb_rst)                          state <= DEFAULT;
                            else if (!usb_spnd)                   state <= ADDRESSED;
                SPND_CONF:  if (usb_rst)                          state <= DEFAULT;
                            else if (!usb_spnd)                   state <= CONFIGURED;
                default:                                          state <= POWERED;
            endcase
        end
    end

    // Address is staged until the status stage commits it; a write in the
    // commit cycle bypasses the stage so the fresh value takes effect.
    always_ff @(posedge clk_4xrate) begin
        if (rst1_sync || usb_rst) begin
            addr_pend <= 7'd0;
            dev_addr  <= 7'd0;
        end else begin
            if (device_addr_wr)
                addr_pend <= device_addr;
            if (addr_commit)
                dev_addr <= device_addr_wr ? device_addr : addr_pend;
        end
    end

    // Active configuration register.
    always_ff @(posedge clk_4xrate) begin
        if (rst1_sync || usb_rst)
            dev_config <= 8'd0;
        else if (cfg_accept)
            dev_config <= device_config;
    end

    // Endpoints are usable only while configured and not suspended.
    always_ff @(posedge clk_4xrate) begin
        if (rst1_sync)
            ep_enable <= '0;
        else
            ep_enable <= ep_cfg_enable & {(NUM_EP-1){state == CONFIGURED}};
    end

    // EP0 toggle reset follows bus reset, re-pulsing while it is held.
    always_ff @(posedge clk_4xrate) begin
        if (rst1_sync)
            tog0_q <= 1'b0;
        else
            tog0_q <= usb_rst;
    end

    for (genvar i = 1; i < NUM_EP; i++) begin : g_ep
        usb_devstate_ep ep_lane (
            .clk_4xrate    (clk_4xrate),
            .rst1_sync     (rst1_sync),
            .usb_rst       (usb_rst),
            .cfg_accept    (cfg_accept),
            .ep_enable     (ep_enable[i]),
            .ep_halt_set   (ep_halt_set[i]),
            .ep_halt_clr   (ep_halt_clr[i]),
            .ep_halt       (ep_halt[i]),
            .togglebit_rst (lane_tog[i])
        );
    end

    // Next value of the saturating suspended-cycle counter.
    always_comb begin
        idle_nxt = '0;
        if (suspended)
            idle_nxt = (idle_cnt == IW'(WAKEUP_IDLE_CYCLES)) ? idle_cnt : idle_cnt + IW'(1);
    end

    // Suspended-cycle counter register.
    always_ff @(posedge clk_4xrate) begin
        if (rst1_sync)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_nxt;
    end

    // Remote wakeup sequencer. Drive starts in the cycle the idle counter
    // reaches saturation, so K is never driven before the minimum idle time.
    always_ff @(posedge clk_4xrate) begin
        if (rst1_sync || usb_rst) begin
            wstate        <= W_IDLE;
            remote_wakeup <= 1'b0;
            wakeup_busy   <= 1'b0;
            drv_cnt       <= '0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (device_wakeup && suspended && remote_wakeup_en) begin
                        wstate      <= W_WAIT;
                        wakeup_busy <= 1'b1;
                    end
                end
                W_WAIT: begin
                    if (!usb_spnd) begin
                        wstate      <= W_IDLE;
                        wakeup_busy <= 1'b0;
                    end else if (idle_nxt == IW'(WAKEUP_IDLE_CYCLES)) begin
                        wstate        <= W_DRIVE;
                        remote_wakeup <= 1'b1;
                        drv_cnt       <= '0;
                    end
                end
                W_DRIVE: begin
                    if (drv_cnt == DW'(WAKEUP_DRIVE_CYCLES - 1)) begin
                        wstate        <= W_HOLD;
                        remote_wakeup <= 1'b0;
                    end else begin
                        drv_cnt <= drv_cnt + DW'(1);
                    end
                end
                W_HOLD: begin
                    if (!usb_spnd) begin
                        wstate      <= W_IDLE;
                        wakeup_busy <= 1'b0;
                    end
                end
                default: begin
                    wstate        <= W_IDLE;
                    remote_wakeup <= 1'b0;
                    wakeup_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/usb_devstate_ctrl.md
USB_DEVSTATE_CTRL -- requirements
Module: usb_devstate_ctrl

Interface
REQ-001 Parameters SHALL be:
- NUM_EP, 16, endpoint count including EP0; legal range 2..16.
- WAKEUP_IDLE_CYCLES, 240000, minimum suspended cycles before remote wakeup may be driven.
- WAKEUP_DRIVE_CYCLES, 48000, duration of remote-wakeup K drive in cycles.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_4xrate, in, 1, the single clock.
- rst1_sync, in, 1, synchronous active-high reset.
- usb_rst, in, 1, bus reset detected.
- usb_spnd, in, 1, bus suspend detected.
- device_addr_wr, in, 1, load pending address.
- device_addr, in, 7, SET_ADDRESS value.
- addr_commit, in, 1, SET_ADDRESS status stage done; commit pending address.
- device_config_wr, in, 1, configuration write strobe.
- device_config, in, 8, configuration value.
- ep_cfg_enable, in, NUM_EP-1 ([NUM_EP-1:1]), endpoints present in the active configuration.
- ep_halt_set, in, NUM_EP-1, per-endpoint SET_FEATURE(HALT).
- ep_halt_clr, in, NUM_EP-1, per-endpoint CLEAR_FEATURE(HALT).
- remote_wakeup_en, in, 1, host-enabled DEVICE_REMOTE_WAKEUP feature.
- device_wakeup, in, 1, wakeup request pulse.
- device_state, out, 3, state code.
- dev_addr, out, 7, effective device address.
- dev_config, out, 8, active configuration.
- ep_enable, out, NUM_EP-1, endpoints usable now.
- ep_halt, out, NUM_EP-1, per-endpoint halt flags.
- togglebit_rst, out, NUM_EP ([NUM_EP-1:0]), one-cycle data-toggle reset pulses.
- remote_wakeup, out, 1, drive K to encoder.
- wakeup_busy, out, 1, wakeup sequence in progress.

Function
REQ-003 device_state SHALL be encoded as: POWERED=0, DEFAULT=1, ADDRESSED=2, CONFIGURED=3, SPND_PWR=4, SPND_DFT=5, SPND_ADDR=6, SPND_CONF=7.

REQ-004 State transitions SHALL be registered, one per cycle, priority left to right:
- POWERED: usb_rst->DEFAULT; usb_spnd->SPND_PWR.
- DEFAULT: usb_spnd->SPND_DFT; dev_addr!=0->ADDRESSED.
- ADDRESSED: usb_rst or dev_addr==0->DEFAULT; usb_spnd->SPND_ADDR; dev_config!=0->CONFIGURED.
- CONFIGURED: usb_rst->DEFAULT; usb_spnd->SPND_CONF; dev_config==0->ADDRESSED.
- SPND_x: usb_rst->DEFAULT; !usb_spnd->x.

REQ-005 device_addr_wr SHALL load a pending register only; dev_addr SHALL update the cycle after addr_commit; simultaneous wr and commit SHALL commit the new device_addr.

REQ-006 usb_rst SHALL clear dev_addr, the pending address, dev_config and all ep_halt bits on the next edge.

REQ-007 device_config_wr SHALL be accepted only in ADDRESSED or CONFIGURED and ignored elsewhere.

REQ-008 An accepted config write SHALL:
- clear all ep_halt bits;
- pulse togglebit_rst[NUM_EP-1:1] for one cycle.

REQ-009 ep_enable SHALL equal ep_cfg_enable AND (device_state==CONFIGURED), registered with one cycle latency.

REQ-010 ep_halt[i] SHALL set on ep_halt_set[i] only while ep_enable[i]=1, and SHALL clear on ep_halt_clr[i]; simultaneous set and clr SHALL clear.

REQ-011 An ep_halt_clr[i] on an enabled endpoint SHALL pulse togglebit_rst[i] for one cycle, even if ep_halt[i] was already 0.

REQ-012 togglebit_rst[0] SHALL pulse for one cycle after usb_rst is asserted; the pulse SHALL repeat while usb_rst stays high.

REQ-013 Idle counter: counts cycles while device_state[2]=1, saturating at WAKEUP_IDLE_CYCLES, and clears on any non-suspended cycle.

REQ-014 Wakeup FSM SHALL have states W_IDLE, W_WAIT, W_DRIVE, W_HOLD:
- W_IDLE->W_WAIT on device_wakeup while device_state[2]=1 and remote_wakeup_en=1; otherwise the request is dropped.
- W_WAIT->W_DRIVE once the idle counter is saturated.
- W_DRIVE holds remote_wakeup=1 for exactly WAKEUP_DRIVE_CYCLES cycles, then goes to W_HOLD.
- W_HOLD->W_IDLE when !usb_spnd.
- wakeup_busy=1 in any state other than W_IDLE.

REQ-015 usb_rst, or leaving suspend before W_DRIVE, SHALL abort the wakeup FSM to W_IDLE with remote_wakeup=0 on the next edge.

REQ-016 Counter widths SHALL be $clog2(param+1); no counter SHALL wrap.

Reset
REQ-017 While rst1_sync=1, all outputs SHALL be 0 (device_state=POWERED) and the wakeup FSM SHALL be in W_IDLE, regardless of other inputs.

REQ-018 Reset asserted mid-wakeup SHALL drop remote_wakeup on the same edge.

Verification (NUM_EP=4, WAKEUP_IDLE_CYCLES=20, WAKEUP_DRIVE_CYCLES=8)
REQ-019 Enumeration: usb_rst pulse, addr_wr 0x05, commit, config_wr 0x01 -> states 1, 2, 3; dev_addr=5 only after commit; togglebit_rst=4'b1110 for one cycle.

REQ-020 Address commit race: wr 0x12 and commit in the same cycle -> dev_addr=0x12 next cycle; a commit with no prior wr in DEFAULT -> dev_addr=0 and state stays 1.

REQ-021 Halt: in CONFIGURED, set ep_halt_set=3'b011, then set and clr bit1 together -> ep_halt=3'b010, togglebit_rst=4'b0010 for one cycle.

REQ-022 Wakeup: SPND_CONF, wakeup_en=1, request at suspended cycle 5 -> remote_wakeup rises at cycle 20 and stays high for 8 cycles; after !usb_spnd -> state 3, wakeup_busy=0.

REQ-023 Aborts:
- usb_rst during W_DRIVE -> remote_wakeup=0 next cycle, state DEFAULT.
- Request with wakeup_en=0 -> wakeup_busy stays 0.
- Config_wr in DEFAULT -> dev_config unchanged.
